// File: rtl/lane_bram_fu.sv
// Simple-dual-port lane-masked block RAM with a configurable read pipeline,
// selectable read-during-write behaviour and a post-reset hardware clear.
module lane_bram_fu #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DEPTH          = 512,
    parameter int LANE_WIDTH     = 64,
    parameter int NUM_LANES      = 16,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              CLK_GATE,
    input  logic                              write_en,
    input  logic [ADDR_WIDTH-1:0]             write_addr,
    input  logic [NUM_LANES-1:0]              write_mask,
    input  logic [LANE_WIDTH*NUM_LANES-1:0]   write_data,
    input  logic                              read_en,
    input  logic [ADDR_WIDTH-1:0]             read_addr,
    output logic [LANE_WIDTH*NUM_LANES-1:0]   read_data,
    output logic                              read_valid,
    output logic                              busy
);

    localparam int W     = LANE_WIDTH * NUM_LANES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;

    logic [W-1:0]            ram [DEPTH];

    logic                    accepting;
    logic                    wr_in_range, rd_in_range;
    logic                    wr_fire, rd_fire;
    logic [W-1:0]            rd_word;

    logic                    ram_we;
    logic [IDX_W-1:0]        ram_idx;
    logic [NUM_LANES-1:0]    ram_mask;
    logic [W-1:0]            ram_wdata;

    logic [W-1:0]            pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;

    // A fully populated address space needs no range check at all.
    if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full_range
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_partial_range
        assign wr_in_range = (write_addr <= LAST_ADDR);
        assign rd_in_range = (read_addr <= LAST_ADDR);
    end

    assign accepting = (state_q == S_IDLE) && CLK_GATE && !RST;
    assign wr_fire   = accepting && write_en && wr_in_range;
    assign rd_fire   = accepting && read_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        busy        = 1'b0;
        case (state_q)
            S_CLEAR: begin
                busy = 1'b1;
                if (CLK_GATE) begin
                    if (clear_ptr_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                    end else begin
                        clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Single physical write port shared by the clear sequencer and the user.
    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = '0;
        ram_mask  = '0;
        ram_wdata = '0;
        if (!RST && CLK_GATE && (state_q == S_CLEAR)) begin
            ram_we   = 1'b1;
            ram_idx  = clear_ptr_q[IDX_W-1:0];
            ram_mask = '1;
        end else if (wr_fire) begin
            ram_we    = 1'b1;
            ram_idx   = write_addr[IDX_W-1:0];
            ram_mask  = write_mask;
            ram_wdata = write_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (ram_mask[i]) begin
                    ram[ram_idx][i*LANE_WIDTH +: LANE_WIDTH] <= ram_wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Write-first bypass only substitutes lanes the colliding write touches.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = ram[read_addr[IDX_W-1:0]];
            if ((WRITE_FIRST != 0) && wr_fire && (write_addr == read_addr)) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (write_mask[i]) begin
                        rd_word[i*LANE_WIDTH +: LANE_WIDTH] = write_data[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // Data stages only load on a valid result so read_data holds between reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else if (CLK_GATE) begin
            pipe_valid[0] <= rd_fire;
            if (rd_fire) begin
                pipe_data[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign read_data  = pipe_data[READ_LATENCY-1];
    assign read_valid = pipe_valid[READ_LATENCY-1];

endmodule
